// File: rtl/ktms_afu_intr_send.sv
// Interrupt sender: takes one interrupt request over valid/ready, issues a tagged PSL command,
// and retries resource-busy responses after a fixed backoff. Request ready only while idle.
module ktms_afu_intr_send #(
   parameter int ctxtid_width = 10,
   parameter int msinum_width = 4,
   parameter int tag_width = 8,
   parameter logic [tag_width-1:0] intr_tag = 8'hE0,
   parameter int retry_max = 3,
   parameter int backoff_cycles = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_intr_v,
   output logic                    i_intr_r,
   input  logic [ctxtid_width-1:0] i_intr_ctxt,
   input  logic [msinum_width-1:0] i_intr_msi,
   output logic                    o_cmd_v,
   input  logic                    i_cmd_r,
   output logic [ctxtid_width-1:0] o_cmd_ctxt,
   output logic [msinum_width-1:0] o_cmd_msi,
   output logic [tag_width-1:0]    o_cmd_tag,
   input  logic                    i_rsp_v,
   input  logic [tag_width-1:0]    i_rsp_tag,
   input  logic [7:0]              i_rsp_code,
   output logic [15:0]             o_intr_cnt,
   output logic                    o_fail,
   output logic                    o_perror
);

   localparam int rc_w = (retry_max > 0) ? $clog2(retry_max + 1) : 1;
   localparam int bc_w = $clog2(backoff_cycles + 1);
   localparam logic [rc_w-1:0] retry_lim = rc_w'(retry_max);
   localparam logic [bc_w-1:0] backoff_init = bc_w'(backoff_cycles);
   localparam logic [7:0] rsp_done = 8'h00;
   localparam logic [7:0] rsp_retry = 8'h05;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;

   state_t state, state_nxt;
   logic [rc_w-1:0] retry_cnt;
   logic [bc_w-1:0] backoff_cnt;

   logic xfer, parity_ok, rsp_hit;
   logic cap_en, perr_set, retry_clr, retry_inc, backoff_load, cnt_inc, fail_set;

   assign i_intr_r  = (state == IDLE);
   assign o_cmd_v   = (state == ISSUE);
   assign o_cmd_tag = intr_tag;
   assign xfer      = i_intr_v & i_intr_r;
   // Odd parity: data bits plus the parity LSB must hold an odd number of ones.
   assign parity_ok = ^i_intr_ctxt;
   assign rsp_hit   = i_rsp_v && (i_rsp_tag == intr_tag);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      cap_en       = 1'b0;
      perr_set     = 1'b0;
      retry_clr    = 1'b0;
      retry_inc    = 1'b0;
      backoff_load = 1'b0;
      cnt_inc      = 1'b0;
      fail_set     = 1'b0;
      case (state)
         IDLE: begin
            if (xfer) begin
               cap_en = 1'b1;
               if (parity_ok) begin
                  state_nxt = ISSUE;
                  retry_clr = 1'b1;
               end else begin
                  perr_set = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (i_cmd_r) state_nxt = WAIT;
         end
         WAIT: begin
            if (rsp_hit) begin
               if (i_rsp_code == rsp_done) begin
                  cnt_inc   = 1'b1;
                  state_nxt = IDLE;
               end else if (i_rsp_code == rsp_retry && retry_cnt < retry_lim) begin
                  retry_inc    = 1'b1;
                  backoff_load = 1'b1;
                  state_nxt    = BACKOFF;
               end else begin
                  fail_set  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         BACKOFF: begin
            if (backoff_cnt == bc_w'(1)) state_nxt = ISSUE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_intr_cnt  <= 16'd0;
         o_fail      <= 1'b0;
         o_perror    <= 1'b0;
         retry_cnt   <= '0;
         backoff_cnt <= '0;
      end else begin
         o_fail <= fail_set;
         if (cnt_inc)  o_intr_cnt <= o_intr_cnt + 16'd1;
         if (perr_set) o_perror <= 1'b1;
         if (retry_clr)      retry_cnt <= '0;
         else if (retry_inc) retry_cnt <= retry_cnt + rc_w'(1);
         if (backoff_load)          backoff_cnt <= backoff_init;
         else if (state == BACKOFF) backoff_cnt <= backoff_cnt - bc_w'(1);
      end
   end

   // Payload needs no reset: it is only observed while o_cmd_v is high.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         o_cmd_ctxt <= i_intr_ctxt;
         o_cmd_msi  <= i_intr_msi;
      end
   end

endmodule

// File: tb/tb_ktms_afu_intr_send.sv
// Bench for ktms_afu_intr_send: per-cycle vector table plus directed retry/reset sequences.
module tb_ktms_afu_intr_send;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_intr_v;
   logic        i_intr_r;
   logic [9:0]  i_intr_ctxt;
   logic [3:0]  i_intr_msi;
   logic        o_cmd_v;
   logic        i_cmd_r;
   logic [9:0]  o_cmd_ctxt;
   logic [3:0]  o_cmd_msi;
   logic [7:0]  o_cmd_tag;
   logic        i_rsp_v;
   logic [7:0]  i_rsp_tag;
   logic [7:0]  i_rsp_code;
   logic [15:0] o_intr_cnt;
   logic        o_fail;
   logic        o_perror;

   ktms_afu_intr_send dut (
      .clk(clk), .reset(reset),
      .i_intr_v(i_intr_v), .i_intr_r(i_intr_r), .i_intr_ctxt(i_intr_ctxt), .i_intr_msi(i_intr_msi),
      .o_cmd_v(o_cmd_v), .i_cmd_r(i_cmd_r), .o_cmd_ctxt(o_cmd_ctxt), .o_cmd_msi(o_cmd_msi),
      .o_cmd_tag(o_cmd_tag), .i_rsp_v(i_rsp_v), .i_rsp_tag(i_rsp_tag), .i_rsp_code(i_rsp_code),
      .o_intr_cnt(o_intr_cnt), .o_fail(o_fail), .o_perror(o_perror)
   );

   always #5 clk = ~clk;

   // {9'h012, parity 1}, {9'h1A5, parity 0}, and the first with its parity flipped
   localparam logic [9:0] ctx_g  = 10'h025;
   localparam logic [9:0] ctx_c2 = 10'h34A;
   localparam logic [9:0] ctx_b  = 10'h024;
   localparam logic [7:0] tag    = 8'hE0;

   typedef struct {
      logic iv; logic [9:0] ctxt; logic [3:0] msi; logic cr;
      logic rv; logic [7:0] rtag; logic [7:0] code;
      logic e_r; logic e_cv; logic [9:0] e_ctxt; logic [3:0] e_msi;
      logic [15:0] e_cnt; logic e_fail; logic e_perr;
   } vec_t;

   vec_t vq[$];
   int ncmp = 0;
   int nerr = 0;
   int ncmd = 0;
   int nfail = 0;

   always @(negedge clk) begin
      if (o_cmd_v && i_cmd_r) ncmd++;
      if (o_fail) nfail++;
   end

   function automatic void add(input logic iv, input logic [9:0] ctxt, input logic [3:0] msi,
                               input logic cr, input logic rv, input logic [7:0] rtag,
                               input logic [7:0] code, input logic e_r, input logic e_cv,
                               input logic [9:0] e_ctxt, input logic [3:0] e_msi,
                               input logic [15:0] e_cnt, input logic e_fail, input logic e_perr);
      vec_t v;
      v.iv = iv; v.ctxt = ctxt; v.msi = msi; v.cr = cr; v.rv = rv; v.rtag = rtag; v.code = code;
      v.e_r = e_r; v.e_cv = e_cv; v.e_ctxt = e_ctxt; v.e_msi = e_msi;
      v.e_cnt = e_cnt; v.e_fail = e_fail; v.e_perr = e_perr;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_req(input logic [9:0] ctxt, input logic [3:0] msi);
      i_intr_v = 1'b1; i_intr_ctxt = ctxt; i_intr_msi = msi; i_cmd_r = 1'b1;
      step();
      i_intr_v = 1'b0;
      chk("issue_cmd_v", 32'(o_cmd_v), 32'd1);
   endtask

   // From an ISSUE cycle with i_cmd_r=1: respond in the first WAIT cycle; returns at cycle R+1.
   task automatic rsp_after_issue(input logic [7:0] code);
      step();
      i_rsp_v = 1'b1; i_rsp_tag = tag; i_rsp_code = code;
      step();
      i_rsp_v = 1'b0;
   endtask

   task automatic backoff_check(input string nm);
      int early = 0;
      repeat (16) begin
         if (o_cmd_v) early++;
         step();
      end
      chk({nm, "_early_cmd"}, 32'(early), 32'd0);
      chk({nm, "_reissue"}, 32'(o_cmd_v), 32'd1);
   endtask

   initial begin
      int c0, f0;
      reset = 1'b1; i_intr_v = 1'b0; i_intr_ctxt = '0; i_intr_msi = '0; i_cmd_r = 1'b0;
      i_rsp_v = 1'b0; i_rsp_tag = '0; i_rsp_code = '0;

      // good request, backpressure + foreign tag, bad parity, hard fail, idle response
      add(1, ctx_g, 3, 1, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0,          0, 1, ctx_g, 3, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, tag, 8'h00,    0, 0, 0, 0, 0, 0, 0);
      add(1, ctx_c2, 5, 0, 0, 0, 0,     1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 9; i++)
         add(0, 0, 0, 0, 0, 0, 0,       0, 1, ctx_c2, 5, 1, 0, 0);
      add(0, 0, 0, 0, 1, tag, 8'h00,    0, 1, ctx_c2, 5, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0,          0, 1, ctx_c2, 5, 1, 0, 0);
      add(0, 0, 0, 0, 1, 8'h11, 8'h00,  0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, tag, 8'h00,    0, 0, 0, 0, 1, 0, 0);
      add(1, ctx_b, 1, 1, 0, 0, 0,      1, 0, 0, 0, 2, 0, 0);
      add(1, ctx_g, 7, 1, 0, 0, 0,      1, 0, 0, 0, 2, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0,          0, 1, ctx_g, 7, 2, 0, 1);
      add(0, 0, 0, 1, 1, tag, 8'h42,    0, 0, 0, 0, 2, 0, 1);
      add(0, 0, 0, 1, 1, tag, 8'h00,    1, 0, 0, 0, 2, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 2, 0, 1);

      repeat (2) step();
      reset = 1'b0;
      chk("rst_intr_r", 32'(i_intr_r), 32'd1);
      chk("rst_cmd_v", 32'(o_cmd_v), 32'd0);
      chk("rst_cnt", 32'(o_intr_cnt), 32'd0);
      chk("rst_fail", 32'(o_fail), 32'd0);
      chk("rst_perror", 32'(o_perror), 32'd0);

      foreach (vq[i]) begin
         vec_t v;
         v = vq[i];
         chk($sformatf("v%0d_intr_r", i), 32'(i_intr_r), 32'(v.e_r));
         chk($sformatf("v%0d_cmd_v", i), 32'(o_cmd_v), 32'(v.e_cv));
         if (v.e_cv) begin
            chk($sformatf("v%0d_ctxt", i), 32'(o_cmd_ctxt), 32'(v.e_ctxt));
            chk($sformatf("v%0d_msi", i), 32'(o_cmd_msi), 32'(v.e_msi));
            chk($sformatf("v%0d_tag", i), 32'(o_cmd_tag), 32'(tag));
         end
         chk($sformatf("v%0d_cnt", i), 32'(o_intr_cnt), 32'(v.e_cnt));
         chk($sformatf("v%0d_fail", i), 32'(o_fail), 32'(v.e_fail));
         chk($sformatf("v%0d_perror", i), 32'(o_perror), 32'(v.e_perr));
         i_intr_v = v.iv; i_intr_ctxt = v.ctxt; i_intr_msi = v.msi; i_cmd_r = v.cr;
         i_rsp_v = v.rv; i_rsp_tag = v.rtag; i_rsp_code = v.code;
         step();
      end
      i_intr_v = 1'b0; i_rsp_v = 1'b0;

      // retry path: 05, 05, 00
      c0 = ncmd; f0 = nfail;
      issue_req(ctx_g, 9);
      rsp_after_issue(8'h05);
      backoff_check("retry1");
      rsp_after_issue(8'h05);
      backoff_check("retry2");
      rsp_after_issue(8'h00);
      chk("retry_cnt", 32'(o_intr_cnt), 32'd3);
      chk("retry_intr_r", 32'(i_intr_r), 32'd1);
      chk("retry_cmds", 32'(ncmd - c0), 32'd3);
      chk("retry_nofail", 32'(nfail - f0), 32'd0);

      // retry exhaustion: four 05 responses
      c0 = ncmd; f0 = nfail;
      issue_req(ctx_c2, 2);
      for (int k = 0; k < 3; k++) begin
         rsp_after_issue(8'h05);
         backoff_check($sformatf("exh%0d", k));
      end
      rsp_after_issue(8'h05);
      chk("exh_fail_hi", 32'(o_fail), 32'd1);
      chk("exh_intr_r", 32'(i_intr_r), 32'd1);
      chk("exh_cnt", 32'(o_intr_cnt), 32'd3);
      step();
      chk("exh_fail_lo", 32'(o_fail), 32'd0);
      chk("exh_cmds", 32'(ncmd - c0), 32'd4);
      chk("exh_fail_cnt", 32'(nfail - f0), 32'd1);
      chk("exh_perror_held", 32'(o_perror), 32'd1);

      // reset while waiting, then a late response
      f0 = nfail;
      issue_req(ctx_g, 4);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rw_intr_r", 32'(i_intr_r), 32'd1);
      chk("rw_cmd_v", 32'(o_cmd_v), 32'd0);
      chk("rw_cnt", 32'(o_intr_cnt), 32'd0);
      chk("rw_perror", 32'(o_perror), 32'd0);
      chk("rw_fail", 32'(o_fail), 32'd0);
      i_cmd_r = 1'b0;
      i_rsp_v = 1'b1; i_rsp_tag = tag; i_rsp_code = 8'h00;
      step();
      i_rsp_v = 1'b0;
      chk("late_cnt", 32'(o_intr_cnt), 32'd0);
      chk("late_cmd_v", 32'(o_cmd_v), 32'd0);
      chk("late_intr_r", 32'(i_intr_r), 32'd1);
      step();
      chk("late_nofail", 32'(nfail - f0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
